// File: rtl/rr_arb4_pkg.sv
// rr_arb4 shared types and round-robin search helper.
// Used by the pick stage and the arbiter control top.
package rr_arb4_pkg;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  localparam int NREQ = 4;

  // Rotating priority search starting at ptr+1; returns {found, idx}.
  // Iterating from the far end lets the nearest requester win last.
  function automatic logic [2:0] rr_pick(
    input logic [NREQ-1:0] req,
    input logic [1:0]      ptr
  );
    logic [1:0] k;
    logic [2:0] r;
    r = 3'b000;
    for (int i = NREQ; i >= 1; i--) begin
      k = ptr + 2'(i);
      if (req[k]) r = {1'b1, k};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb4_pick.sv
// rr_arb4 pick stage: rotate, priority-encode, unrotate.
// Shared by the idle grant path and the re-arbitration path.
module rr_arb4_pick
  import rr_arb4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            found,
  output logic [1:0]      idx
);

  // Winner search from the slot after ptr, with wrap-around.
  always_comb begin
    {found, idx} = rr_pick(req, ptr);
  end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl: 4-client round-robin arbiter, grant held until release.
// Optional forced rotation after HOLD_MAX busy cycles: ARB_TIMEOUT_EN.
module rr_arb4_ctrl
  import rr_arb4_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic            GNT_VLD,
  output logic [1:0]      PTR,
  output logic            IDLE,
  output logic            TMO
);

  if (HOLD_MAX < 1 || HOLD_MAX > (2 ** CW) - 1) begin : g_chk
    $error("HOLD_MAX out of range for CW");
  end

  state_t          state_q;
  state_t          state_d;
  logic [NREQ-1:0] gnt_d;
  logic [1:0]      ptr_d;
  logic [NREQ-1:0] pick_req;
  logic            held;
  logic            found;
  logic [1:0]      idx;
  logic [NREQ-1:0] win_oh;

  assign IDLE   = ~|REQ;
  assign held   = |(REQ & GNT);
  assign win_oh = 4'b0001 << idx;

  // Holder is masked out while busy: it either released or is
  // being rotated away, so it must never win again on this edge.
  assign pick_req = (state_q == S_BUSY) ? (REQ & ~GNT) : REQ;

  rr_arb4_pick u_pick (
    .req   (pick_req),
    .ptr   (PTR),
    .found (found),
    .idx   (idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] HM = CW'(HOLD_MAX);
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          tmo_d;

  assign cnt_inc = (cnt_q == HM) ? cnt_q : cnt_q + CW'(1);
`endif

  // Next-state, grant and pointer selection.
  always_comb begin
    state_d = state_q;
    gnt_d   = GNT;
    ptr_d   = PTR;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_BUSY;
          gnt_d   = win_oh;
          ptr_d   = idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          gnt_d = '0;
        end
      end
      S_BUSY: begin
        if (!held) begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (found) begin
            gnt_d = win_oh;
            ptr_d = idx;
          end else begin
            gnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_inc;
          if (cnt_inc == HM && found) begin
            gnt_d = win_oh;
            ptr_d = idx;
            cnt_d = '0;
            tmo_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Registered grant, pointer and state.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      GNT     <= '0;
      GNT_VLD <= 1'b0;
      PTR     <= 2'd3;
    end else begin
      state_q <= state_d;
      GNT     <= gnt_d;
      GNT_VLD <= |gnt_d;
      PTR     <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle forced-rotation pulse.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
      TMO   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      TMO   <= tmo_d;
    end
  end
`else
  assign TMO = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Bench for rr_arb4_ctrl: reference model plus directed vectors.
// Timeout vectors follow ARB_TIMEOUT_EN.
module tb_rr_arb4_ctrl;

  localparam int HM = 3;

  logic       CLK = 1'b0;
  logic       RN  = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] GNT;
  logic       GNT_VLD;
  logic [1:0] PTR;
  logic       IDLE;
  logic       TMO;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  rr_arb4_ctrl #(.HOLD_MAX(HM), .CW(4)) dut (
    .CLK     (CLK),
    .RN      (RN),
    .REQ     (REQ),
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .PTR     (PTR),
    .IDLE    (IDLE),
    .TMO     (TMO)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: who holds the resource (-1 none), last winner, hold age.
  int holder = -1;
  int last   = 3;
  int hcnt   = 0;
  int tmo_m  = 0;

  function automatic int search(logic [3:0] r, int from, int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge CLK or negedge RN) begin
    int w;
    if (!RN) begin
      holder = -1;
      last   = 3;
      hcnt   = 0;
      tmo_m  = 0;
    end else begin
      tmo_m = 0;
      if (holder < 0 || !REQ[holder]) begin
        w      = search(REQ, last, -1);
        holder = w;
        if (w >= 0) last = w;
        hcnt = 0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (hcnt < HM) hcnt = hcnt + 1;
        if (hcnt == HM) begin
          w = search(REQ, last, holder);
          if (w >= 0) begin
            holder = w;
            last   = w;
            hcnt   = 0;
            tmo_m  = 1;
          end
        end
`endif
      end
    end
  end

  always @(negedge CLK) begin
    int eg;
    eg = (holder < 0) ? 0 : (1 << holder);
    chk("m_gnt", int'(GNT), eg);
    chk("m_vld", int'(GNT_VLD), (holder >= 0) ? 1 : 0);
    chk("m_ptr", int'(PTR), last);
    chk("m_tmo", int'(TMO), tmo_m);
    chk("m_idle", int'(IDLE), (REQ == 4'b0000) ? 1 : 0);
  end

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg[7];
    int tt[7];

    REQ = 4'b1111;
    RN  = 1'b0;
    #7;
    chk("rst_gnt", int'(GNT), 0);
    chk("rst_ptr", int'(PTR), 3);
    chk("rst_idle", int'(IDLE), 0);
    RN = 1'b1;
    step(1);
    chk("rst_first", int'(GNT), 1);

    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("rr_hold", int'(GNT), 1 << k);
      REQ = 4'hF & ~(4'b0001 << k);
      step(1);
      chk("rr_next", int'(GNT), 1 << ((k + 1) % 4));
      REQ = 4'hF;
    end

    REQ = 4'b0100;
    step(1);
    chk("hold_g2", int'(GNT), 4);
    REQ = 4'b0101;
    step(2);
    chk("hold_nopre", int'(GNT), 4);
    REQ = 4'b0001;
    step(1);
    chk("hold_rel", int'(GNT), 1);

    REQ = 4'b0000;
    #1;
    chk("idle_comb", int'(IDLE), 1);
    chk("idle_vld", int'(GNT_VLD), 1);
    step(1);
    chk("idle_gnt", int'(GNT), 0);
    chk("idle_vld0", int'(GNT_VLD), 0);

    REQ = 4'b1000;
    step(1);
    REQ = 4'b0000;
    step(1);
    REQ = 4'b1000;
    step(1);
    chk("wrap_gnt", int'(GNT), 8);
    chk("wrap_ptr", int'(PTR), 3);
    REQ = 4'b0000;
    step(1);

    REQ = 4'b0010;
    step(1);
    chk("ar_gnt", int'(GNT), 2);
    RN = 1'b0;
    #1;
    chk("ar_drop", int'(GNT), 0);
    chk("ar_ptr", int'(PTR), 3);
    chk("ar_vld", int'(GNT_VLD), 0);
    #1;
    RN = 1'b1;
    step(1);
    chk("ar_again", int'(GNT), 2);

    REQ = 4'b0000;
    step(1);
`ifdef ARB_TIMEOUT_EN
    tg = '{1, 1, 1, 2, 2, 2, 1};
    tt = '{0, 0, 0, 1, 0, 0, 1};
`else
    tg = '{1, 1, 1, 1, 1, 1, 1};
    tt = '{0, 0, 0, 0, 0, 0, 0};
`endif
    REQ = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("to_gnt", int'(GNT), tg[i]);
      chk("to_tmo", int'(TMO), tt[i]);
    end
    REQ = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("sat_gnt", int'(GNT), 1);
      chk("sat_tmo", int'(TMO), 0);
    end

    REQ = 4'b0000;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
